// File: rtl/pio_switches_debounced.sv
// Avalon-MM switch/button PIO: per-channel synchronizer, debouncer and edge
// detector feeding DATA/RAW/IRQMASK/EDGECAP registers and one level interrupt.
module pio_switches_debounced #(
    parameter int WIDTH           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    localparam int CW = (DEBOUNCE_CYCLES == 0) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] clr;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;
    logic             unused_wd;

    assign unused_wd = ^writedata;
    assign wr_en     = chipselect & write;
    assign sync      = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            logic st_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) st_q <= 1'b0;
                else       st_q <= sync[i];
            end
            assign stable[i] = st_q;
        end else begin : g_db
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
            logic          st_q, st_d;
            logic [CW-1:0] cnt_q, cnt_d;

            // Accept the new level on the edge that would bring the count to
            // DEBOUNCE_CYCLES, so the counter itself never holds that value.
            always_comb begin
                cnt_d = '0;
                st_d  = st_q;
                if (sync[i] != st_q) begin
                    if (cnt_q == LAST) st_d  = sync[i];
                    else               cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    st_q  <= 1'b0;
                    cnt_q <= '0;
                end else begin
                    st_q  <= st_d;
                    cnt_q <= cnt_d;
                end
            end
            assign stable[i] = st_q;
        end
    end

    always_comb begin
        case (EDGE_TYPE)
            1:       evt = ~stable & prev_q;
            2:       evt = stable ^ prev_q;
            default: evt = stable & ~prev_q;
        endcase
    end

    // Set beats clear when both land on the same bit in the same cycle.
    always_comb begin
        clr       = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        edgecap_d = (edgecap_q & ~clr) | evt;
        mask_d    = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = stable;
            2'd1:    readdata_d[WIDTH-1:0] = sync;
            2'd2:    readdata_d[WIDTH-1:0] = mask_q;
            default: readdata_d[WIDTH-1:0] = edgecap_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q     <= '0;
            mask_q     <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            prev_q     <= stable;
            mask_q     <= mask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & mask_q);
endmodule

// File: tb/tb_pio_switches_debounced.sv
// Directed bench: a 2-channel debounced instance and a 32-channel bypass
// instance with any-edge capture, sharing clock and reset.
module tb_pio_switches_debounced;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic        a_cs, a_wr, a_irq;
    logic [1:0]  a_addr;
    logic [31:0] a_wd, a_rd;
    logic [1:0]  a_in;

    logic        b_cs, b_wr, b_irq;
    logic [1:0]  b_addr;
    logic [31:0] b_wd, b_rd;
    logic [31:0] b_in;

    logic [31:0] v;

    pio_switches_debounced #(.WIDTH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(0)) dut_a (
        .clk(clk), .reset(rst), .chipselect(a_cs), .address(a_addr), .write(a_wr),
        .writedata(a_wd), .readdata(a_rd), .in_port(a_in), .irq(a_irq)
    );

    pio_switches_debounced #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) dut_b (
        .clk(clk), .reset(rst), .chipselect(b_cs), .address(b_addr), .write(b_wr),
        .writedata(b_wd), .readdata(b_rd), .in_port(b_in), .irq(b_irq)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic a_write(input logic [1:0] ad, input logic [31:0] d);
        a_cs = 1'b1; a_addr = ad; a_wr = 1'b1; a_wd = d;
        tick(1);
        a_wr = 1'b0; a_wd = '0;
    endtask

    task automatic a_read(input logic [1:0] ad, output logic [31:0] d);
        a_cs = 1'b1; a_addr = ad;
        tick(1);
        d = a_rd;
    endtask

    task automatic b_write(input logic [1:0] ad, input logic [31:0] d);
        b_cs = 1'b1; b_addr = ad; b_wr = 1'b1; b_wd = d;
        tick(1);
        b_wr = 1'b0; b_wd = '0;
    endtask

    task automatic b_read(input logic [1:0] ad, output logic [31:0] d);
        b_cs = 1'b1; b_addr = ad;
        tick(1);
        d = b_rd;
    endtask

    task automatic test_reset();
        a_cs = 0; a_wr = 0; a_addr = 0; a_wd = 0; a_in = 2'b00;
        b_cs = 0; b_wr = 0; b_addr = 0; b_wd = 0; b_in = '0;
        rst = 1'b1;
        tick(3);
        n_chk++;
        if (a_irq !== 1'b0 || a_rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_hold irq=%b rd=%h required irq=0 rd=0", a_irq, a_rd);
        end
        rst = 1'b0;
        for (int ad = 0; ad < 4; ad++) begin
            a_read(2'(ad), v);
            n_chk++;
            if (v !== 32'h0) begin
                n_fail++; $display("FAIL reset_read addr=%0d got %h required 0", ad, v);
            end
        end
        n_chk++;
        if (a_irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq got %b required 0", a_irq);
        end
    endtask

    // sync after 2 clocks (RAW on readdata at 3); stable after 10, DATA on readdata at 11
    task automatic test_poll();
        a_in = 2'b01; a_cs = 1'b1; a_addr = 2'd1;
        tick(2);
        n_chk++;
        if (a_rd !== 32'h0) begin
            n_fail++; $display("FAIL raw_early got %h required 0", a_rd);
        end
        tick(1);
        n_chk++;
        if (a_rd !== 32'h1) begin
            n_fail++; $display("FAIL raw_latency got %h required 1", a_rd);
        end
        a_addr = 2'd0;
        tick(7);
        n_chk++;
        if (a_rd !== 32'h0) begin
            n_fail++; $display("FAIL data_early got %h required 0", a_rd);
        end
        tick(1);
        n_chk++;
        if (a_rd !== 32'h1) begin
            n_fail++; $display("FAIL data_latency got %h required 1", a_rd);
        end
        a_write(2'd3, 32'h3);
        a_read(2'd3, v);
        n_chk++;
        if (v !== 32'h0) begin
            n_fail++; $display("FAIL poll_w1c got %h required 0", v);
        end
    endtask

    task automatic test_glitch();
        a_in = 2'b11; tick(7); a_in = 2'b01;
        tick(12);
        a_read(2'd0, v);
        n_chk++;
        if (v !== 32'h1) begin
            n_fail++; $display("FAIL glitch7_data got %h required 1", v);
        end
        a_read(2'd3, v);
        n_chk++;
        if (v !== 32'h0) begin
            n_fail++; $display("FAIL glitch7_edgecap got %h required 0", v);
        end
        a_in = 2'b11; tick(9); a_in = 2'b01;
        a_cs = 1'b1; a_addr = 2'd0;
        tick(3);
        n_chk++;
        if (a_rd !== 32'h3) begin
            n_fail++; $display("FAIL pulse9_data got %h required 3", a_rd);
        end
        tick(15);
        a_read(2'd0, v);
        n_chk++;
        if (v !== 32'h1) begin
            n_fail++; $display("FAIL pulse9_return got %h required 1", v);
        end
        a_read(2'd3, v);
        n_chk++;
        if (v !== 32'h2) begin
            n_fail++; $display("FAIL pulse9_edgecap got %h required 2", v);
        end
    endtask

    task automatic test_irq();
        a_write(2'd3, 32'h3);
        a_write(2'd2, 32'h1);
        a_read(2'd2, v);
        n_chk++;
        if (v !== 32'h1) begin
            n_fail++; $display("FAIL mask_readback got %h required 1", v);
        end
        a_in = 2'b11;
        tick(12);
        a_read(2'd3, v);
        n_chk++;
        if (v !== 32'h2 || a_irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_masked edgecap=%h irq=%b required 2/0", v, a_irq);
        end
        a_in = 2'b10; tick(12);
        a_cs = 1'b0; a_in = 2'b11;
        tick(10);
        n_chk++;
        if (a_irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_early got %b required 0", a_irq);
        end
        tick(1);
        n_chk++;
        if (a_irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_rise got %b required 1", a_irq);
        end
        a_write(2'd3, 32'h1);
        n_chk++;
        if (a_irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_clear got %b required 0", a_irq);
        end
        a_read(2'd3, v);
        n_chk++;
        if (v !== 32'h2) begin
            n_fail++; $display("FAIL w1c_partial got %h required 2", v);
        end
    endtask

    // W1C of bit 0 lands on the same edge that captures the bit-0 rising event
    task automatic test_collision();
        a_in = 2'b10; tick(12);
        a_cs = 1'b0; a_in = 2'b11;
        tick(10);
        a_write(2'd3, 32'h1);
        n_chk++;
        if (a_irq !== 1'b1) begin
            n_fail++; $display("FAIL collision_irq got %b required 1", a_irq);
        end
        a_read(2'd3, v);
        n_chk++;
        if (v !== 32'h3) begin
            n_fail++; $display("FAIL collision_edgecap got %h required 3", v);
        end
    endtask

    task automatic test_sweep();
        b_in = 32'h8000_0000; b_cs = 1'b1; b_addr = 2'd0;
        tick(3);
        n_chk++;
        if (b_rd !== 32'h0) begin
            n_fail++; $display("FAIL w32_data_early got %h required 0", b_rd);
        end
        tick(1);
        n_chk++;
        if (b_rd !== 32'h8000_0000) begin
            n_fail++; $display("FAIL w32_data_latency got %h required 80000000", b_rd);
        end
        b_read(2'd3, v);
        n_chk++;
        if (v !== 32'h8000_0000) begin
            n_fail++; $display("FAIL w32_rise_edgecap got %h required 80000000", v);
        end
        b_write(2'd3, 32'h8000_0000);
        b_read(2'd3, v);
        n_chk++;
        if (v !== 32'h0) begin
            n_fail++; $display("FAIL w32_w1c got %h required 0", v);
        end
        b_in = '0; tick(6);
        b_read(2'd3, v);
        n_chk++;
        if (v !== 32'h8000_0000) begin
            n_fail++; $display("FAIL w32_fall_edgecap got %h required 80000000", v);
        end
        b_write(2'd2, 32'hFFFF_FFFF);
        b_read(2'd2, v);
        n_chk++;
        if (v !== 32'hFFFF_FFFF || b_irq !== 1'b1) begin
            n_fail++; $display("FAIL w32_mask mask=%h irq=%b required ffffffff/1", v, b_irq);
        end
        a_write(2'd2, 32'hFFFF_FFFF);
        a_read(2'd2, v);
        n_chk++;
        if (v !== 32'h3) begin
            n_fail++; $display("FAIL w2_mask got %h required 3", v);
        end
    endtask

    task automatic test_reset_mid();
        a_cs = 1'b1; a_addr = 2'd3;
        tick(1);
        a_in = 2'b00;
        tick(5);
        n_chk++;
        if (a_irq !== 1'b1 || a_rd !== 32'h3) begin
            n_fail++; $display("FAIL premid irq=%b rd=%h required 1/3", a_irq, a_rd);
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if (a_irq !== 1'b0 || a_rd !== 32'h0) begin
            n_fail++; $display("FAIL async_reset irq=%b rd=%h required 0/0", a_irq, a_rd);
        end
        a_in = 2'b11; a_addr = 2'd0;
        tick(3);
        rst = 1'b0;
        tick(10);
        n_chk++;
        if (a_rd !== 32'h0) begin
            n_fail++; $display("FAIL post_reset_early got %h required 0", a_rd);
        end
        tick(1);
        n_chk++;
        if (a_rd !== 32'h3) begin
            n_fail++; $display("FAIL post_reset_data got %h required 3", a_rd);
        end
        a_read(2'd3, v);
        n_chk++;
        if (v !== 32'h3 || a_irq !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_edgecap edgecap=%h irq=%b required 3/0", v, a_irq);
        end
    endtask

    initial begin
        test_reset();
        test_poll();
        test_glitch();
        test_irq();
        test_collision();
        test_sweep();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
